lux_sampler: RTL and testbench

Periodic sampling front end between the lux-sensor SPI master and the control FSM. On every sample tick it requests 2^AVG_LOG2 back-to-back readings over the sensor master's valid/ready handshake, accumulates them and truncates to an 8-bit average. It then converts the average to three BCD digits with an iterative double-dabble, one shift per cycle. The FSM consumes the average, the digits and a one-cycle update strobe instead of driving the sensor master directly.

---
 rtl/lux_sampler.sv | 123 ++++++++++++
 tb/tb_lux_sampler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lux_sampler.sv
// lux_sampler: periodic lux sensor sampling, averaging and BCD conversion.
// Feeds the control FSM with avg_o/bcd_o and a one-cycle result strobe.
module lux_sampler #(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        lux_valid,
  input  logic        lux_ready,
  input  logic [7:0]  lux_data,
  output logic [7:0]  avg_o,
  output logic [11:0] bcd_o,
  output logic        result_valid,
  output logic        busy
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [4:0] LAST = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    CONV,
    DONE
  } state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, sum;
  logic [4:0]  n_q;
  logic [2:0]  it_q;
  logic [7:0]  avgr_q, avg_w;
  logic [19:0] dd_q, dd_adj;
  logic        tick;

  assign tick  = enable && (cnt_q == CW'(SAMPLE_PERIOD - 1));
  assign sum   = acc_q + AW'(lux_data);
  assign avg_w = 8'(sum >> AVG_LOG2);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // {hundreds, tens, ones, binary}: add 3 to big nibbles, then shift
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < 3; i++) begin
      if (dd_q[8+4*i +: 4] >= 4'd5)
        dd_adj[8+4*i +: 4] = dd_q[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      n_q          <= '0;
      it_q         <= '0;
      avgr_q       <= '0;
      dd_q         <= '0;
      lux_valid    <= 1'b0;
      avg_o        <= '0;
      bcd_o        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy <= tick;
          if (tick) begin
            acc_q     <= '0;
            n_q       <= '0;
            lux_valid <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (lux_ready) begin
            acc_q     <= sum;
            n_q       <= n_q + 5'd1;
            lux_valid <= 1'b0;
            if (n_q == LAST) begin
              avgr_q  <= avg_w;
              dd_q    <= {12'd0, avg_w};
              it_q    <= '0;
              state_q <= CONV;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          lux_valid <= 1'b1;
          state_q   <= REQ;
        end
        CONV: begin
          dd_q <= dd_adj << 1;
          it_q <= it_q + 3'd1;
          if (it_q == 3'd7) state_q <= DONE;
        end
        DONE: begin
          avg_o        <= avgr_q;
          bcd_o        <= dd_q[19:8];
          result_valid <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lux_sampler.sv
// tb_lux_sampler: random sensor stimulus, reference averages and BCD,
// scoreboard monitor checking results, handshake timing and tick starts.
module tb_lux_sampler;

  localparam int P = 16;
  localparam int A = 2;
  localparam int NS = 1 << A;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        lux_valid;
  logic        lux_ready = 1'b0;
  logic [7:0]  lux_data = 8'h00;
  logic [7:0]  avg_o;
  logic [11:0] bcd_o;
  logic        result_valid;
  logic        busy;

  lux_sampler #(.SAMPLE_PERIOD(P), .AVG_LOG2(A)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .lux_valid(lux_valid),
    .lux_ready(lux_ready),
    .lux_data(lux_data),
    .avg_o(avg_o),
    .bcd_o(bcd_o),
    .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    int bcd;
  } exp_t;

  exp_t expq[$];
  int   sq[$];
  int   nvec = 0;
  int   nfail = 0;
  int   nres = 0;
  int   ncap4 = 0;
  int   dly = 3;
  int   hold_len = 1;
  bit   junk_gap = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endfunction

  // reference: average of the run's samples, decimal digits packed as BCD
  task automatic issue(input int a, input int b, input int c, input int d,
                       input bit want);
    exp_t e;
    int avg;
    sq.push_back(a);
    sq.push_back(b);
    sq.push_back(c);
    sq.push_back(d);
    if (want) begin
      avg   = (a + b + c + d) / NS;
      e.avg = avg;
      e.bcd = (avg / 100) * 256 + ((avg / 10) % 10) * 16 + avg % 10;
      expq.push_back(e);
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 255));
  endfunction

  // sensor master model
  int vcnt = 0;
  int hold_left = 0;
  logic prev_lv_s = 1'b0;

  always @(posedge clk) begin : sensor
    bit rdy;
    #1;
    vcnt = lux_valid ? vcnt + 1 : 0;
    if (lux_valid && vcnt == dly && hold_left == 0) hold_left = hold_len;
    rdy = hold_left > 0;
    if (hold_left > 0) hold_left--;
    if (junk_gap && !lux_valid && prev_lv_s) rdy = 1'b1;
    lux_ready = rdy;
    if (lux_valid && rdy && sq.size() > 0) lux_data = 8'(sq.pop_front());
    else lux_data = 8'hEE;
    prev_lv_s = lux_valid;
  end

  // monitor / scoreboard
  int cyc = 0;
  int ecnt = 0;
  int gap = 0;
  int caps = 0;
  int cap_edge = 0;
  int last_avg = 0;
  int last_bcd = 0;
  bit prev_lv = 1'b0;
  bit prev_rv = 1'b0;
  bit prev_rst = 1'b0;
  bit exp_start = 1'b0;
  bit idle_m = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      caps = 0;
      gap = 0;
      exp_start = 1'b0;
      idle_m = 1'b1;
      last_avg = 0;
      last_bcd = 0;
      ecnt = 0;
      prev_lv = 1'b0;
      prev_rv = 1'b0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("rst_lux_valid", lux_valid, 0);
        chk("rst_avg", avg_o, 0);
        chk("rst_bcd", bcd_o, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
      end
      chk("busy", busy, !idle_m);
      if (result_valid) begin
        chk("rv_width", prev_rv, 0);
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("avg", avg_o, e.avg);
          chk("bcd", bcd_o, e.bcd);
          chk("latency", cyc - cap_edge, 9);
          last_avg = e.avg;
          last_bcd = e.bcd;
        end
        nres++;
        idle_m = 1'b1;
      end
      chk("avg_hold", avg_o, last_avg);
      chk("bcd_hold", bcd_o, last_bcd);
      if (exp_start) begin
        chk("start_after_tick", lux_valid, 1);
        exp_start = 1'b0;
      end else if (gap == 2) begin
        chk("gap_low", lux_valid, 0);
        gap = 1;
      end else if (gap == 1) begin
        chk("gap_end", lux_valid, 1);
        gap = 0;
      end else begin
        chk("spurious_req", lux_valid && !prev_lv, 0);
      end
      if (lux_valid && lux_ready) begin
        caps++;
        if (caps == NS) begin
          caps = 0;
          cap_edge = cyc + 1;
          ncap4++;
        end else begin
          gap = 2;
        end
      end
      if (enable) begin
        if (ecnt % P == P - 1 && idle_m) begin
          exp_start = 1'b1;
          idle_m = 1'b0;
        end
        ecnt++;
      end else begin
        ecnt = 0;
      end
      prev_lv = lux_valid;
      prev_rv = result_valid;
      prev_rst = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_res();
    int n0;
    int t;
    n0 = nres;
    t = 0;
    while (nres == n0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk("result_timeout", int'(nres != n0), 1);
    #1;
  endtask

  initial begin : stim
    int n0;
    int t;
    rst = 1'b1;
    enable = 1'b0;
    step(2);
    rst = 1'b0;
    step(100);

    enable = 1'b1;
    issue(10, 20, 30, 40, 1'b1);
    wait_res();
    issue(255, 255, 255, 255, 1'b1);
    wait_res();
    issue(1, 1, 1, 2, 1'b1);
    wait_res();

    junk_gap = 1'b1;
    issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
    wait_res();
    junk_gap = 1'b0;

    hold_len = 5;
    issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
    wait_res();
    hold_len = 1;

    dly = 20;
    issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
    wait_res();
    issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
    wait_res();
    dly = 3;

    issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
    t = 0;
    while (!lux_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("req_timeout", lux_valid, 1);
    enable = 1'b0;
    wait_res();
    enable = 1'b1;

    issue(77, 88, 99, 111, 1'b0);
    n0 = ncap4;
    t = 0;
    while (ncap4 == n0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk("capture_timeout", int'(ncap4 != n0), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sq.delete();
    issue(3, 50, 200, 180, 1'b1);
    wait_res();

    for (int i = 0; i < 4; i++) begin
      issue(rnd(), rnd(), rnd(), rnd(), 1'b1);
      wait_res();
    end

    enable = 1'b0;
    step(5);
    chk("exp_drained", expq.size(), 0);
    chk("samples_drained", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d results", nres);
    $fatal(1);
  end

endmodule
